// File: rtl/mc_ctrl_irq.sv
// Multi-cycle MIPS control FSM with a vectored, prioritised interrupt front end.
// Exceptions, NMI and N_IRQ maskable lines are latched on rising edges and taken only at PREFETCH.
module mc_ctrl_irq #(
    parameter int N_IRQ   = 4,
    parameter int CAUSE_W = $clog2(N_IRQ + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic [N_IRQ-1:0]   irq,
    input  logic [N_IRQ-1:0]   irq_mask,
    input  logic               nmi,
    input  logic               INTD,
    output logic               isBranch,
    output logic               pcWrite,
    output logic               lorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               aluSrcA,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         PCSource,
    output logic [1:0]         RegDst,
    output logic [1:0]         aluControl,
    output logic               isInterrupted,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [4:0]         state_o
);

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_MEMADDR   = 5'd2,
        S_MEMREAD   = 5'd3,
        S_MEMWB     = 5'd4,
        S_MEMWRITE  = 5'd5,
        S_EXEC      = 5'd6,
        S_ALUWB     = 5'd7,
        S_BRANCH    = 5'd8,
        S_JUMP      = 5'd9,
        S_IEXEC     = 5'd10,
        S_IWB       = 5'd11,
        S_PREFETCH  = 5'd12,
        S_JALR      = 5'd13,
        S_JR        = 5'd14,
        S_JAL       = 5'd15,
        S_IRQ_ENTRY = 5'd16,
        S_ILLEGAL   = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    state_t state, state_next;

    logic [N_IRQ-1:0]   irq_q, irq_pend, irq_ready, irq_sel, irq_grant, ack_q;
    logic               nmi_q, nmi_pend, exc_pend;
    logic               found, take_any, taking;
    logic [CAUSE_W-1:0] irq_sel_cause, cause_sel;

    function automatic logic [1:0] alu_from_funct(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            FN_SUB:  return ALU_SUB;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [1:0] alu_from_op(input logic [5:0] o);
        case (o)
            6'b001100: return ALU_AND;
            6'b001110: return ALU_XOR;
            6'b001101: return ALU_ADD;
            6'b001111: return ALU_ADD;
            default:   return ALU_AND;
        endcase
    endfunction

    // Fixed priority: exception, then NMI, then the lowest enabled maskable line.
    always_comb begin
        irq_ready     = irq_pend & irq_mask & {N_IRQ{~INTD}};
        irq_sel       = '0;
        irq_sel_cause = '0;
        found         = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (irq_ready[i] && !found) begin
                irq_sel[i]    = 1'b1;
                irq_sel_cause = CAUSE_W'(i + 2);
                found         = 1'b1;
            end
        end
        take_any  = exc_pend | nmi_pend | found;
        taking    = (state == S_PREFETCH) && take_any;
        irq_grant = '0;
        if (exc_pend) begin
            cause_sel = '0;
        end else if (nmi_pend) begin
            cause_sel = CAUSE_W'(1);
        end else begin
            cause_sel = irq_sel_cause;
            irq_grant = irq_sel;
        end
    end

    // The edge detectors track the lines during reset so a level held across reset does not pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= irq;
            nmi_q     <= nmi;
            irq_pend  <= '0;
            nmi_pend  <= 1'b0;
            exc_pend  <= 1'b0;
            irq_cause <= '0;
            ack_q     <= '0;
        end else begin
            irq_q    <= irq;
            nmi_q    <= nmi;
            irq_pend <= (irq_pend & ~(taking ? irq_grant : '0)) | (irq & ~irq_q);
            nmi_pend <= (nmi_pend & ~(taking && !exc_pend)) | (nmi & ~nmi_q);
            exc_pend <= (exc_pend & ~taking) | (state == S_ILLEGAL);
            if (taking) begin
                irq_cause <= cause_sel;
                ack_q     <= irq_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_PREFETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_PREFETCH;
        case (state)
            S_PREFETCH:  state_next = take_any ? S_IRQ_ENTRY : S_FETCH;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADDR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = (op[5:2] == 4'b0011) ? S_IEXEC : S_ILLEGAL;
                endcase
            end
            S_MEMADDR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   state_next = S_MEMWB;
            S_EXEC: begin
                case (funct)
                    FN_JALR:                        state_next = S_JALR;
                    FN_JR:                          state_next = S_JR;
                    FN_ADD, FN_AND, FN_XOR, FN_SUB: state_next = S_ALUWB;
                    default:                        state_next = S_ILLEGAL;
                endcase
            end
            S_IEXEC:     state_next = S_IWB;
            S_IRQ_ENTRY: state_next = S_FETCH;
            default:     state_next = S_PREFETCH;
        endcase
    end

    always_comb begin
        isBranch      = 1'b0;
        pcWrite       = 1'b0;
        lorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        aluSrcA       = 1'b0;
        RegWrite      = 1'b0;
        MemtoReg      = 2'b00;
        aluSrcB       = 2'b00;
        PCSource      = 2'b00;
        RegDst        = 2'b00;
        aluControl    = ALU_AND;
        isInterrupted = 1'b0;
        irq_ack       = '0;
        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                pcWrite    = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
            end
            S_DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
            end
            S_MEMADDR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
            end
            S_MEMREAD: lorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                lorD     = 1'b1;
            end
            S_EXEC: begin
                aluSrcA    = 1'b1;
                aluControl = alu_from_funct(funct);
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                isBranch   = 1'b1;
                PCSource   = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEXEC: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = alu_from_op(op);
            end
            S_IWB: RegWrite = 1'b1;
            S_JR: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_ADD;
                pcWrite    = 1'b1;
            end
            S_JALR: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_ADD;
                pcWrite    = 1'b1;
                RegWrite   = 1'b1;
                RegDst     = 2'b11;
                MemtoReg   = 2'b10;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                RegDst   = 2'b11;
                MemtoReg = 2'b10;
                pcWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IRQ_ENTRY: begin
                RegWrite      = 1'b1;
                RegDst        = 2'b10;
                MemtoReg      = 2'b10;
                pcWrite       = 1'b1;
                PCSource      = 2'b11;
                isInterrupted = 1'b1;
                irq_ack       = ack_q;
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule
